intr_ctrl: RTL and testbench

Interrupt controller sitting directly upstream of the program-counter controller. It synchronizes and edge-detects external interrupt lines, latches them as pending, and prioritizes them. It issues a single accepted `interrupt` pulse to the PC controller and tracks the in-service interrupt until the ISR returns. A small register port lets software mask, force, clear and inspect interrupts.

---
 rtl/intr_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_intr_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/intr_ctrl.sv
// Interrupt controller: synchronizes and edge-detects irq lines, latches pending,
// prioritizes lowest index, and hands one request at a time to the PC controller.
module intr_ctrl #(
  parameter int NUM_IRQ     = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pause,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               ack,
  input  logic               iret,
  input  logic               reg_write,
  input  logic [1:0]         reg_addr,
  input  logic [7:0]         reg_writedata,
  output logic [7:0]         reg_readdata,
  output logic               interrupt,
  output logic [2:0]         irq_id,
  output logic               in_service
);

  localparam logic [7:0] IRQ_BITS = 8'((9'd1 << NUM_IRQ) - 9'd1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQUEST  = 2'd1,
    WAIT_ACK = 2'd2,
    SERVICE  = 2'd3
  } state_t;

  function automatic logic [2:0] lowest_set(input logic [7:0] v);
    lowest_set = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) begin
        lowest_set = 3'(i);
      end
    end
  endfunction

  logic [SYNC_STAGES-1:0][NUM_IRQ-1:0] sync_q, sync_d;
  logic [NUM_IRQ-1:0]                  hist_q, hist_d;
  logic [NUM_IRQ-1:0]                  arm_q, arm_d;
  logic [SYNC_STAGES-1:0]              fill_q, fill_d;
  logic [NUM_IRQ-1:0]                  sync_out_s;
  logic [NUM_IRQ-1:0]                  rise_s;

  logic [7:0] pending_q, pending_d;
  logic [7:0] mask_q, mask_d;
  logic       gie_q, gie_d;
  logic [7:0] readdata_q, readdata_d;
  logic [7:0] w1c_s, force_s, ack_clr_s, req_s;

  state_t     state_q, state_d;
  logic       interrupt_q, interrupt_d;
  logic [2:0] irq_id_q, irq_id_d;
  logic       in_service_q, in_service_d;

  // Input synchronizers, history flops and per-line arming after reset
  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], irq_in};
    sync_out_s = sync_q[SYNC_STAGES-1];
    hist_d     = sync_out_s;
    fill_d     = {fill_q[SYNC_STAGES-2:0], 1'b1};
    // A line only arms once it has been seen low through a fully refilled
    // synchronizer, so a line held high across reset never looks like an edge.
    arm_d      = arm_q | ({NUM_IRQ{fill_q[SYNC_STAGES-1]}} & ~sync_out_s);
    rise_s     = sync_out_s & ~hist_q & arm_q;
  end

  // Software register decode and pending/mask/gie next state
  always_comb begin
    w1c_s   = 8'd0;
    force_s = 8'd0;
    mask_d  = mask_q;
    gie_d   = gie_q;
    if (reg_write) begin
      case (reg_addr)
        2'd0:    w1c_s   = reg_writedata & IRQ_BITS;
        2'd1:    mask_d  = reg_writedata & IRQ_BITS;
        2'd2:    gie_d   = reg_writedata[6];
        2'd3:    force_s = reg_writedata & IRQ_BITS;
        default: w1c_s   = 8'd0;
      endcase
    end else begin
      w1c_s = 8'd0;
    end
    // New edges and forced sets take precedence over any clear in the same cycle.
    pending_d = ((pending_q & ~(w1c_s | ack_clr_s)) | 8'(rise_s) | force_s) & IRQ_BITS;
  end

  // Registered read-data mux
  always_comb begin
    case (reg_addr)
      2'd0:    readdata_d = pending_q;
      2'd1:    readdata_d = mask_q;
      2'd2:    readdata_d = {in_service_q, gie_q, 3'b000, irq_id_q};
      2'd3:    readdata_d = 8'd0;
      default: readdata_d = 8'd0;
    endcase
  end

  assign req_s = pending_q & mask_q;

  // Request/service FSM next state and registered outputs
  always_comb begin
    state_d      = state_q;
    interrupt_d  = interrupt_q;
    irq_id_d     = irq_id_q;
    in_service_d = in_service_q;
    ack_clr_s    = 8'd0;
    case (state_q)
      IDLE: begin
        if (gie_q && (|req_s)) begin
          irq_id_d    = lowest_set(req_s);
          interrupt_d = 1'b1;
          state_d     = REQUEST;
        end else begin
          interrupt_d = 1'b0;
          state_d     = IDLE;
        end
      end
      REQUEST: begin
        if (!pause) begin
          interrupt_d = 1'b0;
          state_d     = WAIT_ACK;
        end else begin
          interrupt_d = 1'b1;
          state_d     = REQUEST;
        end
      end
      WAIT_ACK: begin
        if (ack) begin
          ack_clr_s    = 8'd1 << irq_id_q;
          in_service_d = 1'b1;
          state_d      = SERVICE;
        end else begin
          state_d = WAIT_ACK;
        end
      end
      SERVICE: begin
        if (iret) begin
          in_service_d = 1'b0;
          state_d      = IDLE;
        end else begin
          state_d = SERVICE;
        end
      end
      default: begin
        interrupt_d  = 1'b0;
        in_service_d = 1'b0;
        state_d      = IDLE;
      end
    endcase
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q       <= '0;
      hist_q       <= '0;
      arm_q        <= '0;
      fill_q       <= '0;
      pending_q    <= 8'd0;
      mask_q       <= 8'd0;
      gie_q        <= 1'b0;
      readdata_q   <= 8'd0;
      state_q      <= IDLE;
      interrupt_q  <= 1'b0;
      irq_id_q     <= 3'd0;
      in_service_q <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      hist_q       <= hist_d;
      arm_q        <= arm_d;
      fill_q       <= fill_d;
      pending_q    <= pending_d;
      mask_q       <= mask_d;
      gie_q        <= gie_d;
      readdata_q   <= readdata_d;
      state_q      <= state_d;
      interrupt_q  <= interrupt_d;
      irq_id_q     <= irq_id_d;
      in_service_q <= in_service_d;
    end
  end

  assign reg_readdata = readdata_q;
  assign interrupt    = interrupt_q;
  assign irq_id       = irq_id_q;
  assign in_service   = in_service_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed bench for intr_ctrl: each task drives one scenario and checks inline.
module tb_intr_ctrl;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       pause = 1'b0;
  logic [7:0] irq_in = 8'd0;
  logic       ack = 1'b0;
  logic       iret = 1'b0;
  logic       reg_write = 1'b0;
  logic [1:0] reg_addr = 2'd0;
  logic [7:0] reg_writedata = 8'd0;
  logic [7:0] reg_readdata;
  logic       interrupt;
  logic [2:0] irq_id;
  logic       in_service;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] rdat;

  intr_ctrl #(.NUM_IRQ(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .pause(pause), .irq_in(irq_in), .ack(ack), .iret(iret),
    .reg_write(reg_write), .reg_addr(reg_addr), .reg_writedata(reg_writedata),
    .reg_readdata(reg_readdata), .interrupt(interrupt), .irq_id(irq_id), .in_service(in_service)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    reg_write = 1'b1; reg_addr = a; reg_writedata = d;
    tick();
    reg_write = 1'b0; reg_writedata = 8'd0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [7:0] d);
    reg_addr = a;
    tick();
    d = reg_readdata;
  endtask

  task automatic service();
    ack = 1'b1; tick(); ack = 1'b0;
    iret = 1'b1; tick(); iret = 1'b0;
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    tick(); tick();
    checks++; if ({interrupt, in_service, irq_id, reg_readdata} !== 13'd0) begin errors++;
      $display("FAIL reset_outputs: got %h want 0", {interrupt, in_service, irq_id, reg_readdata}); end
    reset = 1'b0;
    rd(2'd1, rdat);
    checks++; if (rdat !== 8'h00) begin errors++; $display("FAIL reset_mask: got %h want 00", rdat); end
    rd(2'd2, rdat);
    checks++; if (rdat !== 8'h00) begin errors++; $display("FAIL reset_status: got %h want 00", rdat); end
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic test_single();
    ack = 1'b1; iret = 1'b1; tick(); ack = 1'b0; iret = 1'b0;
    checks++; if (in_service !== 1'b0) begin errors++; $display("FAIL stray_ack: got %b want 0", in_service); end
    wr(2'd1, 8'h01);
    wr(2'd2, 8'h40);
    irq_in[0] = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL single_early edge%0d: got %b want 0", i, interrupt); end
    end
    tick();
    checks++; if (interrupt !== 1'b1 || irq_id !== 3'd0) begin errors++;
      $display("FAIL single_req: got int=%b id=%0d want int=1 id=0", interrupt, irq_id); end
    tick();
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL single_drop: got %b want 0", interrupt); end
    ack = 1'b1; tick(); ack = 1'b0;
    checks++; if (in_service !== 1'b1) begin errors++; $display("FAIL single_insvc: got %b want 1", in_service); end
    rd(2'd0, rdat);
    checks++; if (rdat !== 8'h00) begin errors++; $display("FAIL single_pending: got %h want 00", rdat); end
    rd(2'd2, rdat);
    checks++; if (rdat !== 8'hC0) begin errors++; $display("FAIL single_status: got %h want c0", rdat); end
    iret = 1'b1; tick(); iret = 1'b0;
    checks++; if (in_service !== 1'b0) begin errors++; $display("FAIL single_iret: got %b want 0", in_service); end
    irq_in[0] = 1'b0;
  endtask

  task automatic test_priority();
    wr(2'd1, 8'hFF);
    wr(2'd2, 8'h40);
    wr(2'd3, 8'h24);
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL prio_early: got %b want 0", interrupt); end
    tick();
    checks++; if (interrupt !== 1'b1 || irq_id !== 3'd2) begin errors++;
      $display("FAIL prio_first: got int=%b id=%0d want int=1 id=2", interrupt, irq_id); end
    tick();
    ack = 1'b1; tick(); ack = 1'b0;
    rd(2'd0, rdat);
    checks++; if (rdat !== 8'h20) begin errors++; $display("FAIL prio_pending: got %h want 20", rdat); end
    iret = 1'b1; tick(); iret = 1'b0;
    checks++; if (interrupt !== 1'b0 || in_service !== 1'b0) begin errors++;
      $display("FAIL prio_iret: got int=%b insvc=%b want 0 0", interrupt, in_service); end
    tick();
    checks++; if (interrupt !== 1'b1 || irq_id !== 3'd5) begin errors++;
      $display("FAIL prio_second: got int=%b id=%0d want int=1 id=5", interrupt, irq_id); end
    tick();
    service();
  endtask

  task automatic test_mask_gie();
    wr(2'd1, 8'h00);
    wr(2'd3, 8'h08);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL masked_req: got %b want 0", interrupt); end
    end
    rd(2'd0, rdat);
    checks++; if (rdat !== 8'h08) begin errors++; $display("FAIL masked_pending: got %h want 08", rdat); end
    wr(2'd2, 8'h00);
    wr(2'd1, 8'h08);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL gie_off_req: got %b want 0", interrupt); end
    end
    wr(2'd2, 8'h40);
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL gie_on_early: got %b want 0", interrupt); end
    tick();
    checks++; if (interrupt !== 1'b1 || irq_id !== 3'd3) begin errors++;
      $display("FAIL gie_on_req: got int=%b id=%0d want int=1 id=3", interrupt, irq_id); end
    tick();
    service();
  endtask

  task automatic test_pause();
    wr(2'd1, 8'hFF);
    wr(2'd3, 8'h10);
    pause = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++; if (interrupt !== 1'b1 || irq_id !== 3'd4) begin errors++;
        $display("FAIL pause_hold cyc%0d: got int=%b id=%0d want int=1 id=4", i, interrupt, irq_id); end
    end
    pause = 1'b0;
    tick();
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL pause_drop: got %b want 0", interrupt); end
    service();
  endtask

  task automatic test_no_nesting();
    wr(2'd3, 8'h01);
    tick();
    checks++; if (interrupt !== 1'b1 || irq_id !== 3'd0) begin errors++;
      $display("FAIL nest_first: got int=%b id=%0d want int=1 id=0", interrupt, irq_id); end
    tick();
    ack = 1'b1; tick(); ack = 1'b0;
    irq_in[1] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL nest_blocked: got %b want 0", interrupt); end
    end
    rd(2'd0, rdat);
    checks++; if (rdat !== 8'h02) begin errors++; $display("FAIL nest_pending: got %h want 02", rdat); end
    iret = 1'b1; tick(); iret = 1'b0;
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL nest_iret: got %b want 0", interrupt); end
    tick();
    checks++; if (interrupt !== 1'b1 || irq_id !== 3'd1) begin errors++;
      $display("FAIL nest_after: got int=%b id=%0d want int=1 id=1", interrupt, irq_id); end
    tick();
    service();
    irq_in[1] = 1'b0;
    wr(2'd2, 8'h00);
    for (int i = 0; i < 4; i++) tick();
    irq_in[1] = 1'b1;
    tick(); tick();
    wr(2'd0, 8'h02);
    rd(2'd0, rdat);
    checks++; if (rdat !== 8'h02) begin errors++; $display("FAIL w1c_race: got %h want 02", rdat); end
    wr(2'd0, 8'h02);
    rd(2'd0, rdat);
    checks++; if (rdat !== 8'h00) begin errors++; $display("FAIL w1c_clear: got %h want 00", rdat); end
    irq_in[1] = 1'b0;
  endtask

  task automatic test_reset_mid();
    wr(2'd1, 8'h04);
    wr(2'd2, 8'h40);
    irq_in[2] = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    checks++; if (interrupt !== 1'b1 || irq_id !== 3'd2) begin errors++;
      $display("FAIL rst_req: got int=%b id=%0d want int=1 id=2", interrupt, irq_id); end
    tick();
    rd(2'd2, rdat);
    checks++; if (rdat !== 8'h42) begin errors++; $display("FAIL rst_status_pre: got %h want 42", rdat); end
    reset = 1'b1;
    #1;
    checks++; if ({interrupt, in_service, irq_id, reg_readdata} !== 13'd0) begin errors++;
      $display("FAIL rst_async: got %h want 0", {interrupt, in_service, irq_id, reg_readdata}); end
    tick(); tick();
    reset = 1'b0;
    wr(2'd1, 8'h04);
    wr(2'd2, 8'h40);
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL rst_held_line: got %b want 0", interrupt); end
    end
    rd(2'd0, rdat);
    checks++; if (rdat !== 8'h00) begin errors++; $display("FAIL rst_pending: got %h want 00", rdat); end
    irq_in[2] = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    irq_in[2] = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL rst_fresh_early: got %b want 0", interrupt); end
    tick();
    checks++; if (interrupt !== 1'b1 || irq_id !== 3'd2) begin errors++;
      $display("FAIL rst_fresh_req: got int=%b id=%0d want int=1 id=2", interrupt, irq_id); end
    tick();
    service();
    irq_in[2] = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_mask_gie();
    test_pause();
    test_no_nesting();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
